// File: rtl/jtdd_vtimer.sv
// Video timing generator: pixel/line counters, blanking, syncs, VBL/IMS CPU strobes.
// Latency: decoded outputs are registered from next-state counters, so they align with hdump/vdump.
// Backpressure: none; cen6 low freezes every output, and rst overrides cen6.
module jtdd_vtimer #(
  parameter int HTOTAL   = 384,
  parameter int HVIS     = 256,
  parameter int HS_START = 304,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 272,
  parameter int VB_END   = 8,
  parameter int VB_START = 248,
  parameter int VS_START = 252,
  parameter int VS_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen6,
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic [8:0] vrender,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS,
  output logic       VBL,
  output logic       IMS,
  output logic       frame
);

  localparam logic [8:0] HLAST = 9'(HTOTAL - 1);
  localparam logic [8:0] VLAST = 9'(VTOTAL - 1);
  localparam logic [8:0] HVIS9 = 9'(HVIS);
  localparam logic [8:0] VBE9  = 9'(VB_END);
  localparam logic [8:0] VBS9  = 9'(VB_START);
  // Sync starts are folded into the counter range so a window may straddle the wrap point.
  localparam logic [8:0] HSS9  = 9'(HS_START % HTOTAL);
  localparam logic [8:0] VSS9  = 9'(VS_START % VTOTAL);
  localparam logic [9:0] HSL10 = 10'(HS_LEN);
  localparam logic [9:0] VSL10 = 10'(VS_LEN);
  localparam logic [9:0] HT10  = 10'(HTOTAL);
  localparam logic [9:0] VT10  = 10'(VTOTAL);

  // Distance of x past the window start, modulo the counter period, compared against the length.
  function automatic logic in_win(input logic [8:0] x, input logic [8:0] start,
                                  input logic [9:0] len, input logic [9:0] total);
    logic [9:0] off;
    if (x >= start) off = {1'b0, x} - {1'b0, start};
    else            off = {1'b0, x} + total - {1'b0, start};
    return off < len;
  endfunction

  logic [8:0] r_hdump, r_vdump, r_vrender;
  logic       r_lhbl, r_lvbl, r_hs, r_vs, r_vbl, r_ims, r_frame;

  logic       w_hwrap, w_vwrap;
  logic [8:0] w_h_nxt, w_v_nxt, w_vr_nxt;
  logic       w_lhbl_nxt, w_lvbl_nxt, w_hs_nxt, w_vs_nxt;

  assign w_hwrap  = (r_hdump == HLAST);
  assign w_vwrap  = w_hwrap && (r_vdump == VLAST);
  assign w_h_nxt  = w_hwrap ? 9'd0 : r_hdump + 9'd1;
  assign w_v_nxt  = !w_hwrap ? r_vdump : (w_vwrap ? 9'd0 : r_vdump + 9'd1);
  assign w_vr_nxt = (w_v_nxt == VLAST) ? 9'd0 : w_v_nxt + 9'd1;

  // Decodes use the next-state counts so the registered strobes land with the count they describe.
  assign w_lhbl_nxt = (w_h_nxt < HVIS9);
  assign w_lvbl_nxt = (w_v_nxt >= VBE9) && (w_v_nxt < VBS9);
  assign w_hs_nxt   = in_win(w_h_nxt, HSS9, HSL10, HT10);
  assign w_vs_nxt   = in_win(w_v_nxt, VSS9, VSL10, VT10);

  // Counter and strobe state: reset restarts at pixel 0 of line 0, cen6 gates every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdump   <= 9'd0;
      r_vdump   <= 9'd0;
      r_vrender <= 9'd1;
      r_lhbl    <= 1'b0;
      r_lvbl    <= 1'b0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_vbl     <= 1'b1;
      r_ims     <= 1'b0;
      r_frame   <= 1'b0;
    end else if (cen6) begin
      r_hdump   <= w_h_nxt;
      r_vdump   <= w_v_nxt;
      r_vrender <= w_vr_nxt;
      r_lhbl    <= w_lhbl_nxt;
      r_lvbl    <= w_lvbl_nxt;
      r_hs      <= w_hs_nxt;
      r_vs      <= w_vs_nxt;
      r_vbl     <= ~w_lvbl_nxt;
      r_ims     <= w_v_nxt[3];
      r_frame   <= r_frame ^ w_vwrap;
    end
  end

  assign hdump   = r_hdump;
  assign vdump   = r_vdump;
  assign vrender = r_vrender;
  assign LHBL    = r_lhbl;
  assign LVBL    = r_lvbl;
  assign HS      = r_hs;
  assign VS      = r_vs;
  assign VBL     = r_vbl;
  assign IMS     = r_ims;
  assign frame   = r_frame;

endmodule
